// File: rtl/pf_pkg.sv
// Shared prefetch address types for the stride prefetcher and the prefetch issue scheduler.
package pf_pkg;

    localparam int unsigned ADDR_SIZE       = 64;
    localparam int unsigned LOG2_BLOCK_SIZE = 6;
    localparam int unsigned CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [CLA_SIZE-1:0]  cla_t;

    typedef enum logic [0:0] {
        StEmpty,
        StPend
    } sched_state_e;

    function automatic cla_t addr_to_cla(addr_t addr);
        return addr[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
    endfunction

    function automatic addr_t cla_to_addr(cla_t cla);
        return {cla, {LOG2_BLOCK_SIZE{1'b0}}};
    endfunction

endpackage

// File: rtl/pf_issue_sched_if.sv
// Candidate inputs from the stride prefetcher plus the L2 prefetch request handshake.
interface pf_issue_sched_if;
    import pf_pkg::*;

    addr_t pref_addr1_i;
    addr_t pref_addr2_i;
    addr_t pref_addr3_i;
    logic  pref_valid1_i;
    logic  pref_valid2_i;
    logic  pref_valid3_i;
    logic  req_valid_o;
    addr_t req_addr_o;
    logic  req_ready_i;

    modport slave (
        input  pref_addr1_i, pref_addr2_i, pref_addr3_i,
        input  pref_valid1_i, pref_valid2_i, pref_valid3_i,
        input  req_ready_i,
        output req_valid_o, req_addr_o
    );

    modport master (
        output pref_addr1_i, pref_addr2_i, pref_addr3_i,
        output pref_valid1_i, pref_valid2_i, pref_valid3_i,
        output req_ready_i,
        input  req_valid_o, req_addr_o
    );

endinterface

// File: rtl/pf_recent_filter.sv
// Round-robin table of recently issued line addresses with one write and three lookup ports.
module pf_recent_filter
    import pf_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  cla_t       wr_cla,
    input  cla_t [2:0] lookup_cla,
    output logic [2:0] lookup_hit
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    cla_t               tag_q [ENTRIES];
    logic [ENTRIES-1:0] vld_q;
    logic [IDX_W-1:0]   wr_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_idx_q <= '0;
        end else if (wr_en) begin
            vld_q[wr_idx_q] <= 1'b1;
            wr_idx_q        <= (wr_idx_q == IDX_W'(ENTRIES - 1)) ? '0 : wr_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx_q] <= wr_cla;
        end
    end

    always_comb begin
        lookup_hit = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (vld_q[i] && tag_q[i] == lookup_cla[j]) begin
                    lookup_hit[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pf_issue_sched.sv
// Prefetch issue scheduler: compacts up to 3 candidates/cycle into a FIFO and issues them one at
// a time on the L2 prefetch port. Optional PF_DEDUP_EN adds a recently-issued/queued dup filter.
module pf_issue_sched
    import pf_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned FILTER_ENTRIES = 8,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pf_issue_sched_if.slave        pf_if,
    input  logic                   demand_busy_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [CNT_W-1:0]       drop_cnt_o,
    output logic [CNT_W-1:0]       issue_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    cla_t             mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [OCC_W-1:0] occ_q;
    sched_state_e     state_q;
    logic             req_valid_q;
    cla_t             req_cla_q;
    logic [CNT_W-1:0] drop_cnt_q, issue_cnt_q;

    cla_t [2:0]       cand_cla;
    logic [2:0]       cand_vld;
    logic [2:0]       dup_hit;
    logic [2:0]       elig;
    cla_t [2:0]       comp_cla;
    logic [1:0]       n_elig;
    logic [OCC_W-1:0] free;
    logic [OCC_W-1:0] n_acc;
    logic [1:0]       n_drop;
    logic             pend, handshake, pop;

    function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] cnt, logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign cand_cla  = {addr_to_cla(pf_if.pref_addr3_i), addr_to_cla(pf_if.pref_addr2_i),
                        addr_to_cla(pf_if.pref_addr1_i)};
    assign cand_vld  = {pf_if.pref_valid3_i, pf_if.pref_valid2_i, pf_if.pref_valid1_i};
    assign pend      = (state_q == StPend);
    assign handshake = pend & pf_if.req_ready_i;
    // A presented request is never retracted, so demand only blocks the next pop.
    assign pop       = ~flush_i & (occ_q != '0) & ~demand_busy_i & (~pend | pf_if.req_ready_i);

`ifdef PF_DEDUP_EN
    logic [2:0]       filt_hit;
    logic [DEPTH-1:0] live;

    pf_recent_filter #(
        .ENTRIES (FILTER_ENTRIES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (handshake),
        .wr_cla     (req_cla_q),
        .lookup_cla (cand_cla),
        .lookup_hit (filt_hit)
    );

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            live[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < occ_q;
        end
    end

    always_comb begin
        dup_hit = filt_hit;
        for (int j = 0; j < 3; j++) begin
            if (pend && req_cla_q == cand_cla[j]) begin
                dup_hit[j] = 1'b1;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (live[i] && mem_q[i] == cand_cla[j]) begin
                    dup_hit[j] = 1'b1;
                end
            end
        end
    end
`else
    assign dup_hit = '0;
`endif

    // In-order compaction; later candidates matching an earlier eligible one are dropped silently.
    always_comb begin
        elig     = '0;
        comp_cla = '0;
        n_elig   = '0;
        for (int j = 0; j < 3; j++) begin
            elig[j] = cand_vld[j] & ~dup_hit[j];
            for (int k = 0; k < j; k++) begin
                if (elig[k] && cand_cla[k] == cand_cla[j]) begin
                    elig[j] = 1'b0;
                end
            end
            if (elig[j]) begin
                comp_cla[n_elig] = cand_cla[j];
                n_elig           = n_elig + 2'd1;
            end
        end
    end

    always_comb begin
        free   = DEPTH_OCC - occ_q;
        n_acc  = (OCC_W'(n_elig) > free) ? free : OCC_W'(n_elig);
        n_drop = n_elig - n_acc[1:0];
        if (flush_i) begin
            n_acc  = '0;
            n_drop = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            wr_ptr_q <= wr_ptr_q + n_acc[PTR_W-1:0];
            occ_q    <= occ_q + n_acc - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (OCC_W'(k) < n_acc) begin
                mem_q[wr_ptr_q + PTR_W'(k)] <= comp_cla[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            req_valid_q <= 1'b0;
            req_cla_q   <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (pop) begin
                        state_q     <= StPend;
                        req_valid_q <= 1'b1;
                        req_cla_q   <= mem_q[rd_ptr_q];
                    end
                end
                StPend: begin
                    if (pop) begin
                        req_cla_q <= mem_q[rd_ptr_q];
                    end else if (pf_if.req_ready_i) begin
                        state_q     <= StEmpty;
                        req_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
            if (handshake) begin
                issue_cnt_q <= sat_add(issue_cnt_q, 2'd1);
            end
        end
    end

    assign pf_if.req_valid_o = req_valid_q;
    assign pf_if.req_addr_o  = cla_to_addr(req_cla_q);
    assign occupancy_o       = occ_q;
    assign drop_cnt_o        = drop_cnt_q;
    assign issue_cnt_o       = issue_cnt_q;

endmodule
